// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the runtime-programmable LUT neuron.
// Provides the FSM state enum and the table depth helper.

package lut_neuron_pkg;

    // INIT walks the table writing zeros; RUN serves lookups and writes.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Table depth for a given fan-in width.
    function automatic int depth_of(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_stream_if.sv
// Lookup stream and configuration bus of the LUT neuron.
// Ports: in_* request, out_* result, cfg_* table programming.
//   master: upstream/downstream/config side
//   slave : the neuron itself

interface lut_neuron_stream_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
);

    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_addr;

    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;

    logic                cfg_we;
    logic [IN_BITS-1:0]  cfg_addr;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_clear;
    logic                cfg_ready;

    modport master (
        output in_valid,
        output in_addr,
        output out_ready,
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        output cfg_clear,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  cfg_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  out_ready,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_clear,
        output in_ready,
        output out_valid,
        output out_data,
        output cfg_ready
    );

endinterface

// File: rtl/lut_neuron_ram.sv
// Distributed truth-table storage: one sync write, one async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.

module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int DEPTH = depth_of(IN_BITS);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem [DEPTH];

    // No reset: contents are rebuilt by the INIT clearer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Async read: a same-edge write is seen only from the next cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_stream.sv
// Pipelined, runtime-programmable truth-table neuron (2-stage lookup).
// Ports: clk, rst_n (sync, active-low), bus (lut_neuron_stream_if.slave).

module lut_neuron_stream
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_neuron_stream_if.slave bus
);

    state_t              state;
    state_t              state_nx;
    logic [IN_BITS-1:0]  clr_idx;
    logic [IN_BITS-1:0]  clr_idx_nx;

    logic                run;
    logic                clear_go;
    logic                en;
    logic                acc;

    logic                s1_valid;
    logic [IN_BITS-1:0]  s1_addr;
    logic                s2_valid;
    logic [OUT_BITS-1:0] s2_data;

    logic                ram_we;
    logic [IN_BITS-1:0]  ram_waddr;
    logic [OUT_BITS-1:0] ram_wdata;
    logic [OUT_BITS-1:0] rd_data;

    assign run      = (state == RUN);
    assign clear_go = run & bus.cfg_clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // clr_idx wraps to 0 after the last entry, ready for the next clear.
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        unique case (state)
            INIT: begin
                clr_idx_nx = clr_idx + IN_BITS'(1);
                if (clr_idx == '1) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.cfg_clear) begin
                    state_nx   = INIT;
                    clr_idx_nx = '0;
                end
            end
            default: begin
                state_nx   = INIT;
                clr_idx_nx = '0;
            end
        endcase
    end

    // Clearer owns the write port in INIT; a clear beats a cfg write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus.cfg_addr;
        ram_wdata = bus.cfg_data;
        if (!run) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = '0;
        end else if (bus.cfg_we && !bus.cfg_clear) begin
            ram_we    = 1'b1;
        end
    end

    lut_neuron_ram #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(s1_addr),
        .rdata(rd_data)
    );

    // Whole pipe advances together; no skid buffer.
    assign en  = ~s2_valid | bus.out_ready;
    assign acc = bus.in_valid & run & en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (clear_go) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= acc;
            s1_addr  <= bus.in_addr;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= rd_data;
            end
        end
    end

    assign bus.in_ready  = run & en;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.cfg_ready = run;

endmodule

// File: tb/tb_lut_neuron_stream.sv
// Self-checking bench for lut_neuron_stream.
// Scoreboard of expected lookups, drained by an output monitor.

module tb_lut_neuron_stream;

    localparam int IB    = 6;
    localparam int OB    = 1;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lut_neuron_stream_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();

    lut_neuron_stream #(
        .IN_BITS (IB),
        .OUT_BITS(OB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    logic [OB-1:0] model [DEPTH];
    logic [OB-1:0] sb [$];
    logic          rdy_seen;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic          iv,
                        input logic [IB-1:0] ia,
                        input logic          we,
                        input logic [IB-1:0] wa,
                        input logic [OB-1:0] wd,
                        input logic          clr,
                        input logic          ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_addr   = ia;
        bus.cfg_we    = we;
        bus.cfg_addr  = wa;
        bus.cfg_data  = wd;
        bus.cfg_clear = clr;
        bus.out_ready = ordy;
        #1;
        rdy_seen = bus.in_ready;
        if (we && bus.cfg_ready && !clr) model[wa] = wd;
        if (clr && bus.cfg_ready) begin
            for (int k = 0; k < DEPTH; k++) model[k] = '0;
            sb.delete();
        end else if (iv && bus.in_ready) begin
            sb.push_back(model[ia]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, ordy);
    endtask

    task automatic look(input logic [IB-1:0] a);
        step(1'b1, a, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [IB-1:0] a, input logic [OB-1:0] d);
        step(1'b0, '0, 1'b1, a, d, 1'b0, 1'b1);
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!bus.cfg_ready && n < 200) begin
            idle(1'b1);
            n++;
        end
    endtask

    task automatic drain(input string tag);
        repeat (4) idle(1'b1);
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                n_pop++;
                check("out_data", bus.out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.cfg_clear = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) idle(1'b1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);

        rst_n = 1'b1;
        wait_run(n);
        check("init_len", n, 64);
        check("run_in_ready", bus.in_ready, 1);

        p0 = n_pop;
        for (int i = 0; i < DEPTH; i++) look(IB'(i));
        drain("sweep_drain");
        check("sweep_count", n_pop - p0, 64);

        wr(6'h12, 1'b1);
        wr(6'h33, 1'b1);
        look(6'h12);
        check("lat_e1_valid", bus.out_valid, 0);
        look(6'h11);
        check("lat_e2_valid", bus.out_valid, 1);
        check("lat_e2_data", bus.out_data, 1);
        look(6'h33);
        check("lat_e3_valid", bus.out_valid, 1);
        check("lat_e3_data", bus.out_data, 0);
        idle(1'b1);
        check("lat_e4_valid", bus.out_valid, 1);
        check("lat_e4_data", bus.out_data, 1);
        idle(1'b1);
        check("lat_e5_valid", bus.out_valid, 0);
        drain("stream_drain");

        step(1'b1, 6'h12, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 6'h11, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 6'h3f, 1'b0, '0, '0, 1'b0, 1'b0);
            check("stall_in_ready", rdy_seen, 0);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, 1);
        end
        p0 = n_pop;
        drain("stall_drain");
        check("stall_count", n_pop - p0, 2);

        look(6'h20);
        step(1'b1, 6'h20, 1'b1, 6'h20, 1'b1, 1'b0, 1'b1);
        drain("coll_drain");

        step(1'b1, 6'h12, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 6'h33, 1'b0, '0, '0, 1'b0, 1'b0);
        check("pre_clr_valid", bus.out_valid, 1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        check("clr_flush", bus.out_valid, 0);
        check("clr_cfg_ready", bus.cfg_ready, 0);
        n = 1;
        while (!bus.cfg_ready && n < 200) begin
            step(1'b0, '0, n == 1, 6'h05, 1'b1, n == 10, 1'b1);
            n++;
        end
        check("reinit_len", n, 65);
        look(6'h12);
        look(6'h33);
        look(6'h05);
        look(6'h20);
        drain("clr_drain");

        wr(6'h07, 1'b1);
        step(1'b0, '0, 1'b1, 6'h2a, 1'b1, 1'b1, 1'b1);
        wait_run(n);
        check("we_clr_init_len", n, 64);
        for (int i = 0; i < DEPTH; i++) look(IB'(i));
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
